// File: rtl/alu_mult_seq.sv
// alu_mult_seq: 32-cycle shift-and-add multiplier that drives a shared ALU for its additions.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module alu_mult_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_gin,
  input  logic [31:0] alu_sum
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [2:0] GIN_ADD  = 3'b010;
  localparam logic [2:0] GIN_PASS = 3'b011;
  logic [1:0]  state_q, state_d;
  logic [31:0] mc_q, mc_d, mp_q, mp_d, acc_q, acc_d, prod_q, prod_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        run_last, zero_start, in_run;
  assign in_run = state_q == RUN;
`ifdef MULT_EARLY_EXIT_EN
  // Stop once no set multiplier bits remain after this cycle's shift.
  assign run_last   = (cnt_q == 6'd31) || (mp_q[31:1] == 31'd0);
  assign zero_start = mplier == 32'd0;
`else
  assign run_last   = cnt_q == 6'd31;
  assign zero_start = 1'b0;
`endif
  assign busy    = in_run;
  assign done    = state_q == DONE;
  assign prod    = prod_q;
  assign alu_a   = in_run ? acc_q : 32'd0;
  assign alu_b   = in_run ? mc_q : 32'd0;
  assign alu_gin = (in_run && mp_q[0]) ? GIN_ADD : GIN_PASS;
  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    if (in_run) begin
      acc_d = alu_sum;
      mc_d  = {mc_q[30:0], 1'b0};
      mp_d  = {1'b0, mp_q[31:1]};
      cnt_d = cnt_q + 6'd1;
      if (run_last) begin
        state_d = DONE;
        prod_d  = alu_sum;
      end
    end else if (start) begin
      mc_d    = mcand;
      mp_d    = mplier;
      acc_d   = 32'd0;
      cnt_d   = 6'd0;
      state_d = zero_start ? DONE : RUN;
      prod_d  = zero_start ? 32'd0 : prod_q;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mc_q    <= 32'd0;
      mp_q    <= 32'd0;
      acc_q   <= 32'd0;
      cnt_q   <= 6'd0;
      prod_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end
endmodule

// File: tb/tb_alu_mult_seq.sv
// tb_alu_mult_seq: random and directed scoreboard bench for alu_mult_seq with a behavioural ALU.
module tb_alu_mult_seq;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] mcand = '0, mplier = '0;
  logic        busy, done;
  logic [31:0] prod, alu_a, alu_b, alu_sum;
  logic [2:0]  alu_gin;
  typedef struct { logic [31:0] p; int c; } exp_t;
  exp_t q[$];
  int cyc = 0, pass = 0, total = 0;
  int last_a = -100, last_end = -100;
  logic [31:0] last_prod = '0;
  alu_mult_seq dut (
    .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .prod(prod), .alu_a(alu_a), .alu_b(alu_b),
    .alu_gin(alu_gin), .alu_sum(alu_sum)
  );
  assign alu_sum = (alu_gin == 3'b010) ? alu_a + alu_b : alu_a;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
  endtask
  function automatic int lat(input logic [31:0] m);
    int hb = 0;
    for (int i = 0; i < 32; i++) if (m[i]) hb = i + 1;
`ifdef MULT_EARLY_EXIT_EN
    return hb;
`else
    return (hb >= 0) ? 32 : 32;
`endif
  endfunction
  // One clock of stimulus; an operation is accepted only if the model says the block is not running.
  task automatic step(input logic s, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    start = s; mcand = a; mplier = b;
    @(posedge clk);
    #1;
    if (s && cyc >= last_end + 1) begin
      n = lat(b);
      last_a = cyc;
      last_end = cyc + n;
      q.push_back('{a * b, cyc + n});
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0);
  endtask
  task automatic op(input logic [31:0] a, input logic [31:0] b);
    step(1'b1, a, b);
    idle(36);
  endtask
  task automatic check_reset_outs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_prod"}, prod, 0);
    chk({nm, "_alu_a"}, alu_a, 0);
    chk({nm, "_alu_b"}, alu_b, 0);
    chk({nm, "_alu_gin"}, alu_gin, 3'b011);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outs("mid_reset");
    q.delete();
    last_a = -100; last_end = -100; last_prod = '0;
    #1 reset = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", busy, cyc >= last_a && cyc < last_end);
      if (done) begin
        if (q.size() == 0) chk("spurious_done", done, 0);
        else begin
          chk("prod", prod, q[0].p);
          chk("done_cycle", cyc, q[0].c);
          last_prod = q[0].p;
          void'(q.pop_front());
        end
      end else if (!(cyc >= last_a && cyc < last_end)) begin
        chk("prod_hold", prod, last_prod);
        chk("idle_alu", {alu_a, alu_b, alu_gin}, {64'd0, 3'b011});
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    #1 check_reset_outs("reset");
    reset = 1'b0;
    op(32'd3, 32'd5);
    op(32'hFFFF_FFFF, 32'd2);
    op(32'h0001_0000, 32'h0001_0000);
    op(32'h1234, 32'd1);
    op(32'h5678, 32'd0);
    step(1'b1, 32'd6, 32'd4);
    idle(9);
    step(1'b1, 32'd7, 32'd7);
    idle(30);
    step(1'b1, 32'd9, 32'd9);
    idle(15);
    pulse_reset();
    op(32'd2, 32'd3);
    for (int i = 0; i < 120; i++) step(1'b1, $urandom, (i % 3 == 0) ? $urandom_range(0, 255) : $urandom);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 9) < 3, $urandom, (i % 2 == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom);
    idle(40);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/alu_mult_seq.md
ALU_MULT_SEQ -- requirements
Module: alu_mult_seq

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- mcand  in  32  multiplicand, latched on accepted start.
- mplier  in  32  multiplier, latched on accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- prod  out  32  low 32 bits of the unsigned product; holds until the next accepted start.
- alu_a  out  32  operand A to the shared 32-bit ALU.
- alu_b  out  32  operand B to the shared 32-bit ALU.
- alu_gin  out  3  ALU control line: 010=ADD, 011=pass A.
- alu_sum  in  32  ALU result, combinational, same cycle.

Function
REQ-002 The block SHALL implement a three-state machine: IDLE, RUN and DONE.
REQ-003 In IDLE or DONE, start=1 at a rising edge SHALL be accepted with these effects:
- latch mcand into MC and mplier into MP;
- clear accumulator ACC and cycle counter CNT (6 bits);
- enter RUN.
REQ-004 Each RUN cycle SHALL drive the ALU and update state as follows:
- alu_a=ACC, alu_b=MC;
- alu_gin=010 if MP[0]=1, otherwise 011;
- at the edge: ACC<=alu_sum, MC<=MC<<1 (zero fill, bit 31 discarded), MP<=MP>>1 (zero fill), CNT<=CNT+1.
REQ-005 RUN SHALL exit to DONE at the edge where CNT reaches 32; only MULT_EARLY_EXIT_EN modifies this exit rule (REQ-015).
REQ-006 On entry to DONE, prod SHALL be loaded with the final ACC value.
REQ-007 done SHALL be 1 in exactly the DONE cycle; busy SHALL be 1 exactly in RUN.
REQ-008 DONE SHALL last one cycle:
- go to RUN if start=1 (accepted as in REQ-003);
- otherwise go to IDLE.
REQ-009 start while busy=1 SHALL be ignored and SHALL NOT alter MC, MP, ACC, CNT or prod.
REQ-010 Outside RUN, the ALU outputs SHALL be alu_a=0, alu_b=0, alu_gin=011.
REQ-011 The arithmetic SHALL be modulo 2^32; overflow SHALL NOT be flagged, and the ALU v/n/zout outputs SHALL NOT be used.
REQ-012 Latency SHALL be: done asserts N+1 clock edges after the start-accepting edge, where N is the number of RUN cycles (32 by default).

Reset
REQ-013 reset=1 SHALL immediately and asynchronously force the following, regardless of edge or current state (including mid-RUN):
- state=IDLE, busy=0, done=0, prod=0;
- ACC=0, MC=0, MP=0, CNT=0;
- alu_a=0, alu_b=0, alu_gin=011.
REQ-014 After reset deasserts, the first start accepted SHALL behave per REQ-003; no partial result from an interrupted operation SHALL appear on prod.

Configuration
REQ-015 Macro MULT_EARLY_EXIT_EN:
- when defined, RUN SHALL also exit to DONE at the edge where the updated MP becomes 0, so N = (index of highest set bit of mplier)+1;
- when defined and mplier=0, an accepted start SHALL go directly to DONE (N=0, prod=0);
- when not defined, N=32 for every operand and the MP=0 early-exit logic SHALL be absent.
REQ-016 prod values SHALL be identical with and without MULT_EARLY_EXIT_EN; only latency differs.

Verification
REQ-017 mcand=3, mplier=5, start pulse -> busy for 32 cycles, done 33 edges after accept, prod=0x0000000F (macro off).
REQ-018 mcand=0xFFFFFFFF, mplier=2 -> prod=0xFFFFFFFE; mcand=0x00010000, mplier=0x00010000 -> prod=0x00000000 (wrap).
REQ-019 Pulse start=1 with mcand=7, mplier=7 at RUN cycle 10 of an active 6*4 operation -> prod=0x00000018, and no second done.
REQ-020 Assert reset at RUN cycle 15 of 9*9 -> same cycle busy=0, done=0, prod=0, alu_gin=011; then 2*3 -> prod=6.
REQ-021 With MULT_EARLY_EXIT_EN: mplier=1, mcand=0x1234 -> done 2 edges after accept, prod=0x1234; mplier=0 -> done 1 edge after, prod=0.
REQ-022 start held high continuously -> back-to-back operations DONE->RUN with no IDLE cycle, and one done pulse per operation.
